// File: rtl/quad_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_counter
// Description : Rotary-encoder front end. Synchronises and debounces rot_a,
//               rot_b and btn, decodes quadrature at x1/x2/x4 resolution and
//               keeps a bounded wrap/saturate up/down position count.
//               Optional feature macro: QENC_VELOCITY_EN (adds the vel output).
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_counter #(
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MODE            = 2,
  parameter int CNT_MIN         = 0,
  parameter int CNT_MAX         = 9999,
  parameter int WRAP            = 1
`ifdef QENC_VELOCITY_EN
  ,
  parameter int VEL_WIN_LOG2    = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rot_a,
  input  logic                 rot_b,
  input  logic                 btn,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 err,
  output logic                 btn_pulse
`ifdef QENC_VELOCITY_EN
  ,
  output logic signed [CNT_WIDTH-1:0] vel
`endif
);

  localparam int c_db_w   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int c_init_w = $clog2(DEBOUNCE_CYCLES + 3);

  localparam logic [c_db_w-1:0]    c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_init_w-1:0]  c_init_last = c_init_w'(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_WIDTH-1:0] c_min       = CNT_WIDTH'(CNT_MIN);
  localparam logic [CNT_WIDTH-1:0] c_max       = CNT_WIDTH'(CNT_MAX);
  localparam bit                   c_wrap      = (WRAP != 0);
  localparam bit                   c_x1        = (MODE == 0);
  localparam bit                   c_x2        = (MODE == 1);
  localparam bit                   c_x4        = (MODE == 2);

  localparam logic [0:0] c_st_init = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  // Bit order throughout: [2]=A, [1]=B, [0]=button.
  logic [2:0] w_raw;
  logic [2:0] w_filt;
  assign w_raw = {rot_a, rot_b, btn};

  for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
    logic              r_sync1;
    logic              r_sync2;
    logic              r_filt;
    logic [c_db_w-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_filt   <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_filt) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_db_last) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    assign w_filt[gi] = r_filt;
  end

  logic [2:0]           r_prev;
  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [c_init_w-1:0]  r_init_cnt;
  logic                 w_run;
  logic                 w_up;
  logic                 w_dn;
  logic                 w_ill;
  logic                 w_btn_rise;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_step_up;
  logic                 r_step_dn;
  logic                 r_err;
  logic                 r_btn_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 3'b000;
    end else begin
      r_prev <= w_filt;
    end
  end

  // INIT holds off decoding until the filters have settled on the idle input level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_init;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_st_init) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_init: if (r_init_cnt == c_init_last) w_state_nxt = c_st_run;
      c_st_run:  w_state_nxt = c_st_run;
      default:   w_state_nxt = c_st_init;
    endcase
  end

  always_comb begin
    w_run = (r_state == c_st_run);
  end

  always_comb begin
    w_up  = 1'b0;
    w_dn  = 1'b0;
    w_ill = 1'b0;
    if (w_run) begin
      case ({r_prev[2:1], w_filt[2:1]})
        4'b0001: w_up  = c_x4 | c_x1;
        4'b0111: w_up  = c_x4 | c_x2;
        4'b1110: w_up  = c_x4;
        4'b1000: w_up  = c_x4 | c_x2;
        4'b0100: w_dn  = c_x4 | c_x1;
        4'b1101: w_dn  = c_x4 | c_x2;
        4'b1011: w_dn  = c_x4;
        4'b0010: w_dn  = c_x4 | c_x2;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: w_ill = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_btn_rise = w_run & w_filt[0] & ~r_prev[0];

  always_comb begin
    w_count_nxt = r_count;
    if (w_btn_rise) begin
      w_count_nxt = c_min;
    end else if (w_up) begin
      if (r_count == c_max) w_count_nxt = c_wrap ? c_min : c_max;
      else                  w_count_nxt = r_count + 1'b1;
    end else if (w_dn) begin
      if (r_count == c_min) w_count_nxt = c_wrap ? c_max : c_min;
      else                  w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= c_min;
      r_step_up   <= 1'b0;
      r_step_dn   <= 1'b0;
      r_err       <= 1'b0;
      r_btn_pulse <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_step_up   <= w_up;
      r_step_dn   <= w_dn;
      r_err       <= w_ill;
      r_btn_pulse <= w_btn_rise;
    end
  end

  assign count     = r_count;
  assign step_up   = r_step_up;
  assign step_dn   = r_step_dn;
  assign err       = r_err;
  assign btn_pulse = r_btn_pulse;

`ifdef QENC_VELOCITY_EN
  localparam logic signed [CNT_WIDTH-1:0] c_acc_max = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic signed [CNT_WIDTH-1:0] c_acc_min = {1'b1, {(CNT_WIDTH-1){1'b0}}};

  logic [VEL_WIN_LOG2-1:0]     r_win;
  logic signed [CNT_WIDTH-1:0] r_acc;
  logic signed [CNT_WIDTH-1:0] r_vel;
  logic signed [CNT_WIDTH-1:0] w_acc_nxt;
  logic signed [CNT_WIDTH-1:0] w_step_val;

  always_comb begin
    w_step_val = '0;
    if (w_up)      w_step_val = CNT_WIDTH'(1);
    else if (w_dn) w_step_val = {CNT_WIDTH{1'b1}};
    w_acc_nxt = r_acc;
    if (w_up && (r_acc != c_acc_max))      w_acc_nxt = r_acc + 1'b1;
    else if (w_dn && (r_acc != c_acc_min)) w_acc_nxt = r_acc - 1'b1;
  end

  // The step landing on the window boundary opens the new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= '0;
      r_acc <= '0;
      r_vel <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      if (&r_win) begin
        r_vel <= r_acc;
        r_acc <= w_step_val;
      end else begin
        r_acc <= w_acc_nxt;
      end
    end
  end

  assign vel = r_vel;
`endif

endmodule
`default_nettype wire
